// File: rtl/tdm_pkg.sv
// Shared constants and types for the ST-bus timeslot scheduler.
package tdm_pkg;
  localparam int FRAME_LEN     = 512;
  localparam int SLOTS         = 32;
  localparam int BITS_PER_SLOT = 8;

  localparam int CNT_W  = $clog2(FRAME_LEN);
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int BIT_W  = $clog2(BITS_PER_SLOT);

  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} sync_state_e;

  // Per-slot enable bits, cfg_data order {rx_n, tx_n, rx_t, tx_t}
  localparam int TX_T = 0;
  localparam int RX_T = 1;
  localparam int TX_N = 2;
  localparam int RX_N = 3;

  typedef logic [3:0] slot_en_t;
endpackage

// File: rtl/tdm_frame_sync.sv
// F0 frame alignment: position counter, hunt/confirm/flywheel FSM, miss tracking.
module tdm_frame_sync
  import tdm_pkg::*;
#(
  parameter int CONFIRM_FRAMES = 2,
  parameter int MISS_LIMIT     = 3
) (
  input  logic             c4,
  input  logic             rst,
  input  logic             f0,
  output logic [CNT_W-1:0] cnt,
  output logic             locked,
  output logic             swap,
  output logic             sync_err
);
  localparam int CW = $clog2(CONFIRM_FRAMES + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  sync_state_e   state;
  logic [CW-1:0] confirm_cnt;
  logic [MW-1:0] miss_cnt;
  logic          early_seen;
  logic          at_end, pulse, miss_evt;

  assign at_end = (cnt == LAST);
  assign pulse  = !f0;
  assign locked = (state == LOCKED);
  assign swap   = locked && at_end;
  // A frame costs at most one early strike plus one missing-F0 strike.
  assign miss_evt = locked && (at_end ? !pulse : (pulse && !early_seen));

  always_ff @(posedge c4) begin
    if (rst) begin
      state       <= HUNT;
      cnt         <= '0;
      confirm_cnt <= '0;
      miss_cnt    <= '0;
      early_seen  <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      cnt      <= at_end ? '0 : cnt + 1'b1;
      case (state)
        HUNT: begin
          if (pulse) begin
            cnt         <= '0;
            confirm_cnt <= '0;
            state       <= CONFIRM;
          end
        end
        CONFIRM: begin
          if (at_end) begin
            if (pulse) begin
              confirm_cnt <= confirm_cnt + 1'b1;
              if (confirm_cnt == CW'(CONFIRM_FRAMES - 1)) begin
                state      <= LOCKED;
                miss_cnt   <= '0;
                early_seen <= 1'b0;
              end
            end else begin
              state <= HUNT;
            end
          end else if (pulse) begin
            cnt         <= '0;
            confirm_cnt <= '0;
          end
        end
        LOCKED: begin
          // Flywheel: cnt is never realigned here.
          if (at_end)     early_seen <= 1'b0;
          else if (pulse) early_seen <= 1'b1;
          if (miss_evt) begin
            sync_err <= 1'b1;
            if (miss_cnt == MW'(MISS_LIMIT - 1)) begin
              state    <= HUNT;
              miss_cnt <= '0;
            end else begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          end else if (at_end) begin
            miss_cnt <= '0;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end
endmodule

// File: rtl/tdm_slot_scheduler.sv
// Timeslot scheduler top: double-buffered slot map and registered per-bit clock enables.
module tdm_slot_scheduler
  import tdm_pkg::*;
#(
  parameter int CONFIRM_FRAMES = 2,
  parameter int MISS_LIMIT     = 3
) (
  input  logic              c4,
  input  logic              rst,
  input  logic              f0,
  input  logic              cfg_we,
  input  logic [SLOT_W-1:0] cfg_addr,
  input  logic [3:0]        cfg_data,
  output logic              clk_en_tx_t,
  output logic              clk_en_rx_t,
  output logic              clk_en_tx_n,
  output logic              clk_en_rx_n,
  output logic [SLOT_W-1:0] slot_num,
  output logic [BIT_W-1:0]  bit_num,
  output logic              frame_start,
  output logic              locked,
  output logic              sync_err
);
  logic [CNT_W-1:0]  cnt;
  logic              swap;
  slot_en_t          shadow [SLOTS];
  slot_en_t          active [SLOTS];
  logic [SLOT_W-1:0] slot;
  logic [BIT_W-1:0]  bitpos;
  logic              bit_tick;
  slot_en_t          cur;

  tdm_frame_sync #(
    .CONFIRM_FRAMES(CONFIRM_FRAMES),
    .MISS_LIMIT    (MISS_LIMIT)
  ) u_sync (
    .c4      (c4),
    .rst     (rst),
    .f0      (f0),
    .cnt     (cnt),
    .locked  (locked),
    .swap    (swap),
    .sync_err(sync_err)
  );

  assign slot     = cnt[CNT_W-1 -: SLOT_W];
  assign bitpos   = cnt[1 +: BIT_W];
  assign bit_tick = locked && !cnt[0];
  assign cur      = active[slot];

  always_ff @(posedge c4) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      clk_en_tx_t <= 1'b0;
      clk_en_rx_t <= 1'b0;
      clk_en_tx_n <= 1'b0;
      clk_en_rx_n <= 1'b0;
      slot_num    <= '0;
      bit_num     <= '0;
      frame_start <= 1'b0;
    end else begin
      if (cfg_we) shadow[cfg_addr] <= cfg_data;
      // Shadow copies over at the last cycle of a locked frame, so a write in
      // that same cycle only reaches the following frame.
      if (swap || !locked) begin
        for (int i = 0; i < SLOTS; i++) active[i] <= shadow[i];
      end
      clk_en_tx_t <= bit_tick && cur[TX_T];
      clk_en_rx_t <= bit_tick && cur[RX_T];
      clk_en_tx_n <= bit_tick && cur[TX_N];
      clk_en_rx_n <= bit_tick && cur[RX_N];
      frame_start <= bit_tick && (cnt == '0);
      if (!locked) begin
        slot_num <= '0;
        bit_num  <= '0;
      end else if (bit_tick) begin
        slot_num <= slot;
        bit_num  <= bitpos;
      end
    end
  end
endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Directed bench for tdm_slot_scheduler: lock acquisition, map double-buffering, flywheel, reset.
`timescale 1ns/1ps
module tb_tdm_slot_scheduler;
  logic       c4 = 1'b0;
  logic       rst = 1'b1;
  logic       f0 = 1'b1;
  logic       cfg_we = 1'b0;
  logic [4:0] cfg_addr = '0;
  logic [3:0] cfg_data = '0;
  logic       clk_en_tx_t, clk_en_rx_t, clk_en_tx_n, clk_en_rx_n;
  logic [4:0] slot_num;
  logic [2:0] bit_num;
  logic       frame_start, locked, sync_err;

  int errors = 0;
  int checks = 0;
  logic [3:0] map_m [32];

  tdm_slot_scheduler dut (
    .c4         (c4),
    .rst        (rst),
    .f0         (f0),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .clk_en_tx_t(clk_en_tx_t),
    .clk_en_rx_t(clk_en_rx_t),
    .clk_en_tx_n(clk_en_tx_n),
    .clk_en_rx_n(clk_en_rx_n),
    .slot_num   (slot_num),
    .bit_num    (bit_num),
    .frame_start(frame_start),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 c4 = ~c4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One c4 cycle with f0 level fv; leaves us 1ns after the edge.
  task automatic cyc(input logic fv);
    f0 = fv;
    @(posedge c4);
    #1;
    f0 = 1'b1;
    cfg_we = 1'b0;
  endtask

  function automatic logic [3:0] en_vec();
    return {clk_en_rx_n, clk_en_tx_n, clk_en_rx_t, clk_en_tx_t};
  endfunction

  // F0 at F, F+512, F+1024: locked expected from F+1025, nothing before.
  task automatic acquire(input string tag);
    int seen;
    seen = 0;
    cyc(1'b0);
    for (int i = 0; i < 1023; i++) begin
      cyc(i == 511 ? 1'b0 : 1'b1);
      seen = seen | int'({en_vec(), frame_start, locked});
    end
    chk({tag, " quiet before lock"}, seen, 0);
    cyc(1'b0);
    chk({tag, " locked"}, locked, 1);
  endtask

  // Runs the 512 cycles whose cnt is k=0..511; after each, outputs reflect position k.
  task automatic run_frame(input string tag, input bit lk, input bit give, input int early,
                           input int wk, input logic [4:0] wa, input logic [3:0] wd,
                           output int nerr, output int npulse);
    int bad;
    logic [3:0] exp;
    bad = 0; nerr = 0; npulse = 0;
    for (int k = 0; k < 512; k++) begin
      if (k == wk) begin
        cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd;
      end
      cyc(((k == 511) && give) || (k == early) ? 1'b0 : 1'b1);
      exp = (lk && (k % 2 == 0)) ? map_m[k / 16] : 4'b0000;
      if (en_vec() !== exp) bad++;
      if (frame_start !== (lk && k == 0)) bad++;
      if (lk && (k % 2 == 0)) begin
        if (slot_num !== 5'(k / 16) || bit_num !== 3'((k / 2) % 8)) bad++;
      end else if (!lk && (slot_num !== 5'd0 || bit_num !== 3'd0)) begin
        bad++;
      end
      npulse += $countones(en_vec());
      nerr += int'(sync_err);
    end
    chk({tag, " schedule"}, bad, 0);
  endtask

  initial begin
    int ne, np;
    foreach (map_m[i]) map_m[i] = 4'b0000;

    rst = 1'b1;
    repeat (3) cyc(1'b1);
    chk("rst locked", locked, 0);
    chk("rst sync_err", sync_err, 0);
    chk("rst frame_start", frame_start, 0);
    chk("rst enables", en_vec(), 0);
    chk("rst slot_num", slot_num, 0);
    chk("rst bit_num", bit_num, 0);
    rst = 1'b0;

    cfg_we = 1'b1; cfg_addr = 5'd1; cfg_data = 4'b0001;
    cyc(1'b1);
    map_m[1] = 4'b0001;
    acquire("s1");

    run_frame("s2 slot1", 1, 1, -1, -1, 5'd0, 4'd0, ne, np);
    chk("s2 pulses", np, 8);
    chk("s2 sync_err", ne, 0);

    run_frame("s3 wr@100", 1, 1, -1, 100, 5'd5, 4'b1010, ne, np);
    chk("s3 wr@100 pulses", np, 8);
    map_m[5] = 4'b1010;
    run_frame("s3 wr@511", 1, 1, -1, 511, 5'd5, 4'b0000, ne, np);
    chk("s3 slot5 live pulses", np, 24);
    run_frame("s3 swap-cycle wr held", 1, 1, -1, -1, 5'd0, 4'd0, ne, np);
    chk("s3 held pulses", np, 24);
    map_m[5] = 4'b0000;
    run_frame("s3 cleared", 1, 1, -1, -1, 5'd0, 4'd0, ne, np);
    chk("s3 cleared pulses", np, 8);

    run_frame("s5 early", 1, 1, 501, -1, 5'd0, 4'd0, ne, np);
    chk("s5 early sync_err", ne, 1);
    chk("s5 early locked", locked, 1);
    run_frame("s4 miss1", 1, 0, -1, -1, 5'd0, 4'd0, ne, np);
    chk("s4 miss1 sync_err", ne, 1);
    chk("s4 miss1 locked", locked, 1);
    run_frame("s4 miss2", 1, 0, -1, -1, 5'd0, 4'd0, ne, np);
    chk("s4 miss2 sync_err", ne, 1);
    chk("s4 miss2 locked", locked, 1);
    run_frame("s4 miss3", 1, 0, -1, -1, 5'd0, 4'd0, ne, np);
    chk("s4 miss3 sync_err", ne, 1);
    chk("s4 miss3 locked", locked, 0);
    run_frame("s4 hunt", 0, 0, -1, -1, 5'd0, 4'd0, ne, np);
    chk("s4 hunt pulses", np, 0);

    // Capture, then a misplaced F0 in CONFIRM becomes the new alignment.
    cyc(1'b0);
    repeat (199) cyc(1'b1);
    acquire("s5 realign");
    run_frame("s5 relocked", 1, 1, -1, -1, 5'd0, 4'd0, ne, np);
    chk("s5 relocked pulses", np, 8);

    repeat (300) cyc(1'b1);
    rst = 1'b1;
    cyc(1'b1);
    rst = 1'b0;
    chk("s6 locked", locked, 0);
    chk("s6 enables", en_vec(), 0);
    chk("s6 frame_start", frame_start, 0);
    chk("s6 slot/bit", {slot_num, bit_num}, 0);
    map_m[1] = 4'b0000;
    acquire("s6");
    run_frame("s6 empty map", 1, 1, -1, -1, 5'd0, 4'd0, ne, np);
    chk("s6 map cleared pulses", np, 0);
    chk("s6 sync_err", ne, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
